// File: rtl/icache_sa.sv
// Set-associative instruction cache that refills lines over AXI in LINE_WORDS/2 64-bit beats.
// Hits respond 2 edges after accept. One fetch is in flight at a time; the response is held until rready_i.
module icache_sa #(
  parameter int SETS       = 16,
  parameter int WAYS       = 2,
  parameter int LINE_WORDS = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_master_arready,
  output logic        io_master_arvalid,
  output logic [31:0] io_master_araddr,
  output logic [3:0]  io_master_arid,
  output logic [7:0]  io_master_arlen,
  output logic [2:0]  io_master_arsize,
  output logic [1:0]  io_master_arburst,
  output logic        io_master_rready,
  input  logic        io_master_rvalid,
  input  logic [1:0]  io_master_rresp,
  input  logic [63:0] io_master_rdata,
  input  logic        io_master_rlast,
  input  logic [3:0]  io_master_rid,
  output logic        arready_o,
  input  logic        arvalid_i,
  input  logic [31:0] araddr_i,
  input  logic        rready_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  input  logic        flush_i,
  output logic [31:0] hit_cnt_o,
  output logic [31:0] miss_cnt_o
);
  localparam int WW    = $clog2(LINE_WORDS);
  localparam int OFS   = 2 + WW;
  localparam int IDXW  = $clog2(SETS);
  localparam int TAGW  = 32 - OFS - IDXW;
  localparam int BEATS = LINE_WORDS / 2;

  typedef enum logic [2:0] {IDLE, LOOKUP, REFILL_AR, REFILL_R, RESP} state_t;
  state_t state_q, state_d;

  logic [31:0]     addr_q;
  logic [WW-1:0]   beat_q;
  logic            way_q, err_q, flush_pend_q, rst_done_q;
  logic [SETS-1:0] valid_q [WAYS];
  logic [SETS-1:0] lru_q;
  logic [TAGW-1:0] tag_q [WAYS][SETS];
  logic [31:0]     data_q [WAYS][SETS][LINE_WORDS];
  logic [31:0]     hit_cnt_q, miss_cnt_q;

  logic [IDXW-1:0] idx;
  logic [TAGW-1:0] tag;
  logic [WW-1:0]   word, wsel_lo, wsel_hi;
  logic            hit, hit_way, victim;
  logic            flush_now, accept, beat_fire, last_fire, beat_in_line;
  logic            unused_ok;

  assign idx          = addr_q[OFS +: IDXW];
  assign tag          = addr_q[31 -: TAGW];
  assign word         = addr_q[2 +: WW];
  assign wsel_lo      = beat_q << 1;
  assign wsel_hi      = (beat_q << 1) | WW'(1);
  assign flush_now    = (state_q == IDLE) && (flush_i || flush_pend_q);
  assign accept       = arvalid_i && arready_o;
  assign beat_fire    = (state_q == REFILL_R) && io_master_rvalid;
  assign last_fire    = beat_fire && io_master_rlast;
  assign beat_in_line = beat_q < WW'(BEATS);
  assign hit_cnt_o    = hit_cnt_q;
  assign miss_cnt_o   = miss_cnt_q;
  assign unused_ok    = ^{io_master_rid, addr_q[1:0]};

  always_comb begin
    hit     = 1'b0;
    hit_way = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[w][idx] && (tag_q[w][idx] == tag)) begin
        hit     = 1'b1;
        hit_way = 1'(w);
      end
    end
  end

  // Fill an empty way first (way0 preferred), otherwise evict the least recently used way.
  always_comb begin
    if (WAYS == 1)                   victim = 1'b0;
    else if (!valid_q[0][idx])       victim = 1'b0;
    else if (!valid_q[WAYS-1][idx])  victim = 1'b1;
    else                             victim = lru_q[idx];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (accept) state_d = LOOKUP;
      LOOKUP:    state_d = hit ? RESP : REFILL_AR;
      REFILL_AR: if (io_master_arready) state_d = REFILL_R;
      REFILL_R:  if (last_fire) state_d = RESP;
      RESP:      if (rready_i) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    arready_o         = rst_done_q && (state_q == IDLE) && !flush_i && !flush_pend_q;
    io_master_arvalid = 1'b0;
    io_master_araddr  = '0;
    io_master_arid    = '0;
    io_master_arlen   = '0;
    io_master_arsize  = '0;
    io_master_arburst = '0;
    io_master_rready  = 1'b0;
    rvalid_o          = 1'b0;
    rdata_o           = '0;
    case (state_q)
      REFILL_AR: begin
        io_master_arvalid = 1'b1;
        io_master_araddr  = {addr_q[31:OFS], {OFS{1'b0}}};
        io_master_arlen   = 8'(BEATS - 1);
        io_master_arsize  = 3'b011;
        io_master_arburst = 2'b01;
      end
      REFILL_R: io_master_rready = 1'b1;
      RESP: begin
        rvalid_o = 1'b1;
        rdata_o  = data_q[way_q][idx][word];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rst_done_q   <= 1'b0;
      addr_q       <= '0;
      beat_q       <= '0;
      way_q        <= 1'b0;
      err_q        <= 1'b0;
      flush_pend_q <= 1'b0;
      lru_q        <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
      for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
    end else begin
      rst_done_q <= 1'b1;
      if (accept) addr_q <= araddr_i;
      if (flush_now)    flush_pend_q <= 1'b0;
      else if (flush_i) flush_pend_q <= 1'b1;
      if (state_q == LOOKUP) begin
        if (hit) begin
          way_q      <= hit_way;
          lru_q[idx] <= ~hit_way;
          if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 32'd1;
        end else begin
          way_q <= victim;
          err_q <= 1'b0;
          if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
      end
      // Beats past the end of the line are dropped; only rlast closes the burst.
      if (beat_fire) begin
        if (beat_in_line) beat_q <= beat_q + WW'(1);
        if (io_master_rresp != 2'b00) err_q <= 1'b1;
        if (io_master_rlast) begin
          beat_q              <= '0;
          valid_q[way_q][idx] <= !err_q && (io_master_rresp == 2'b00);
          lru_q[idx]          <= ~way_q;
        end
      end
      if (flush_now) begin
        lru_q <= '0;
        for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (beat_fire && beat_in_line) begin
      data_q[way_q][idx][wsel_lo] <= io_master_rdata[31:0];
      data_q[way_q][idx][wsel_hi] <= io_master_rdata[63:32];
    end
    if (last_fire) tag_q[way_q][idx] <= tag;
  end
endmodule

// File: tb/tb_icache_sa.sv
// Directed bench for icache_sa: hit/miss, LRU replacement, error refill, flush and reset cases.
module tb_icache_sa;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        io_master_arready = 1'b0;
  logic        io_master_arvalid;
  logic [31:0] io_master_araddr;
  logic [3:0]  io_master_arid;
  logic [7:0]  io_master_arlen;
  logic [2:0]  io_master_arsize;
  logic [1:0]  io_master_arburst;
  logic        io_master_rready;
  logic        io_master_rvalid = 1'b0;
  logic [1:0]  io_master_rresp = 2'b00;
  logic [63:0] io_master_rdata = '0;
  logic        io_master_rlast = 1'b0;
  logic [3:0]  io_master_rid = 4'd0;
  logic        arready_o;
  logic        arvalid_i = 1'b0;
  logic [31:0] araddr_i = '0;
  logic        rready_i = 1'b1;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        flush_i = 1'b0;
  logic [31:0] hit_cnt_o, miss_cnt_o;

  int n_tests = 0;
  int n_fail  = 0;

  icache_sa dut (
    .clock(clock), .reset(reset),
    .io_master_arready(io_master_arready), .io_master_arvalid(io_master_arvalid),
    .io_master_araddr(io_master_araddr), .io_master_arid(io_master_arid),
    .io_master_arlen(io_master_arlen), .io_master_arsize(io_master_arsize),
    .io_master_arburst(io_master_arburst), .io_master_rready(io_master_rready),
    .io_master_rvalid(io_master_rvalid), .io_master_rresp(io_master_rresp),
    .io_master_rdata(io_master_rdata), .io_master_rlast(io_master_rlast),
    .io_master_rid(io_master_rid), .arready_o(arready_o), .arvalid_i(arvalid_i),
    .araddr_i(araddr_i), .rready_i(rready_i), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .flush_i(flush_i), .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drives one fetch and, on a miss, answers the refill with two beats (second beat carries rr1).
  task automatic fetch(input logic [31:0] a, input logic [63:0] d0, input logic [63:0] d1,
                       input logic [1:0] rr1, output logic [31:0] data, output bit missed,
                       output logic [31:0] ar_a, output logic [7:0] ar_l, output logic [2:0] ar_s,
                       output int lat, output bit to);
    int n;
    missed = 1'b0; to = 1'b0; data = '0; ar_a = '0; ar_l = '0; ar_s = '0; lat = 0;
    n = 0;
    while (!arready_o && n < 20) begin tick(); n++; end
    arvalid_i = 1'b1; araddr_i = a;
    tick();
    arvalid_i = 1'b0; lat = 1;
    n = 0;
    while (!rvalid_o && n < 50) begin
      if (io_master_arvalid) begin
        missed = 1'b1; ar_a = io_master_araddr; ar_l = io_master_arlen; ar_s = io_master_arsize;
        io_master_arready = 1'b1;
        tick();
        io_master_arready = 1'b0;
        io_master_rvalid = 1'b1; io_master_rdata = d0; io_master_rresp = 2'b00; io_master_rlast = 1'b0;
        tick();
        io_master_rdata = d1; io_master_rresp = rr1; io_master_rlast = 1'b1;
        tick();
        io_master_rvalid = 1'b0; io_master_rlast = 1'b0; io_master_rresp = 2'b00;
      end else begin
        tick();
        lat++;
      end
      n++;
    end
    if (!rvalid_o) to = 1'b1;
    data = rdata_o;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) tick();
    n_tests++; if (arready_o !== 1'b0) begin n_fail++; $display("FAIL rst_arready: got %b want 0", arready_o); end
    n_tests++; if (rvalid_o !== 1'b0 || rdata_o !== 32'h0) begin n_fail++; $display("FAIL rst_resp: got %b/%h want 0/0", rvalid_o, rdata_o); end
    n_tests++; if (io_master_arvalid !== 1'b0 || io_master_rready !== 1'b0) begin n_fail++; $display("FAIL rst_axi: got %b/%b want 0/0", io_master_arvalid, io_master_rready); end
    n_tests++; if (hit_cnt_o !== 32'd0 || miss_cnt_o !== 32'd0) begin n_fail++; $display("FAIL rst_cnt: got %0d/%0d want 0/0", hit_cnt_o, miss_cnt_o); end
    reset = 1'b1;
    #1;
    n_tests++; if (arready_o !== 1'b0) begin n_fail++; $display("FAIL rst_release_arready: got %b want 0", arready_o); end
    tick();
    n_tests++; if (arready_o !== 1'b1) begin n_fail++; $display("FAIL rst_first_edge_arready: got %b want 1", arready_o); end
  endtask

  task automatic test_miss();
    logic [31:0] d, ara; logic [7:0] arl; logic [2:0] ars; bit m, to; int lat;
    fetch(32'h8000_0004, 64'h22222222_11111111, 64'h44444444_33333333, 2'b00, d, m, ara, arl, ars, lat, to);
    n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL miss_timeout: got %b want 0", to); end
    n_tests++; if (m !== 1'b1) begin n_fail++; $display("FAIL miss_ar_seen: got %b want 1", m); end
    n_tests++; if (ara !== 32'h8000_0000) begin n_fail++; $display("FAIL miss_araddr: got %h want 80000000", ara); end
    n_tests++; if (arl !== 8'd1 || ars !== 3'd3) begin n_fail++; $display("FAIL miss_arlen_size: got %0d/%0d want 1/3", arl, ars); end
    n_tests++; if (d !== 32'h2222_2222) begin n_fail++; $display("FAIL miss_rdata: got %h want 22222222", d); end
    n_tests++; if (miss_cnt_o !== 32'd1 || hit_cnt_o !== 32'd0) begin n_fail++; $display("FAIL miss_cnt: got %0d/%0d want 1/0", miss_cnt_o, hit_cnt_o); end
  endtask

  task automatic test_hit();
    logic [31:0] d, ara; logic [7:0] arl; logic [2:0] ars; bit m, to; int lat;
    fetch(32'h8000_000C, 64'h0, 64'h0, 2'b00, d, m, ara, arl, ars, lat, to);
    n_tests++; if (to !== 1'b0 || m !== 1'b0) begin n_fail++; $display("FAIL hit_no_ar: got to=%b ar=%b want 0/0", to, m); end
    n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL hit_latency: got %0d want 2", lat); end
    n_tests++; if (d !== 32'h4444_4444) begin n_fail++; $display("FAIL hit_rdata: got %h want 44444444", d); end
    n_tests++; if (hit_cnt_o !== 32'd1 || miss_cnt_o !== 32'd1) begin n_fail++; $display("FAIL hit_cnt: got %0d/%0d want 1/1", hit_cnt_o, miss_cnt_o); end
  endtask

  task automatic test_lru();
    logic [31:0] d, ara; logic [7:0] arl; logic [2:0] ars; bit m, to; int lat;
    fetch(32'h8000_0000, 64'h0, 64'h0, 2'b00, d, m, ara, arl, ars, lat, to);
    n_tests++; if (m !== 1'b0 || d !== 32'h1111_1111) begin n_fail++; $display("FAIL lru_hit0: got ar=%b %h want 0 11111111", m, d); end
    fetch(32'h8000_0100, 64'hA1A1A1A1_A0A0A0A0, 64'hA3A3A3A3_A2A2A2A2, 2'b00, d, m, ara, arl, ars, lat, to);
    n_tests++; if (m !== 1'b1 || d !== 32'hA0A0_A0A0) begin n_fail++; $display("FAIL lru_fill1: got ar=%b %h want 1 a0a0a0a0", m, d); end
    fetch(32'h8000_0200, 64'hB1B1B1B1_B0B0B0B0, 64'hB3B3B3B3_B2B2B2B2, 2'b00, d, m, ara, arl, ars, lat, to);
    n_tests++; if (m !== 1'b1 || ara !== 32'h8000_0200) begin n_fail++; $display("FAIL lru_fill2: got ar=%b %h want 1 80000200", m, ara); end
    fetch(32'h8000_0100, 64'h0, 64'h0, 2'b00, d, m, ara, arl, ars, lat, to);
    n_tests++; if (m !== 1'b0 || d !== 32'hA0A0_A0A0) begin n_fail++; $display("FAIL lru_kept: got ar=%b %h want 0 a0a0a0a0", m, d); end
    fetch(32'h8000_0000, 64'hC1C1C1C1_C0C0C0C0, 64'hC3C3C3C3_C2C2C2C2, 2'b00, d, m, ara, arl, ars, lat, to);
    n_tests++; if (m !== 1'b1 || d !== 32'hC0C0_C0C0) begin n_fail++; $display("FAIL lru_evicted: got ar=%b %h want 1 c0c0c0c0", m, d); end
    n_tests++; if (hit_cnt_o !== 32'd3 || miss_cnt_o !== 32'd4) begin n_fail++; $display("FAIL lru_cnt: got %0d/%0d want 3/4", hit_cnt_o, miss_cnt_o); end
  endtask

  task automatic test_err_refill();
    logic [31:0] d, ara; logic [7:0] arl; logic [2:0] ars; bit m, to; int lat;
    fetch(32'h8000_0040, 64'h55555555_66666666, 64'h77777777_88888888, 2'b10, d, m, ara, arl, ars, lat, to);
    n_tests++; if (m !== 1'b1 || d !== 32'h6666_6666) begin n_fail++; $display("FAIL err_returned: got ar=%b %h want 1 66666666", m, d); end
    fetch(32'h8000_0040, 64'h99999999_AAAAAAAA, 64'hBBBBBBBB_CCCCCCCC, 2'b00, d, m, ara, arl, ars, lat, to);
    n_tests++; if (m !== 1'b1 || d !== 32'hAAAA_AAAA) begin n_fail++; $display("FAIL err_not_valid: got ar=%b %h want 1 aaaaaaaa", m, d); end
    fetch(32'h8000_004C, 64'h0, 64'h0, 2'b00, d, m, ara, arl, ars, lat, to);
    n_tests++; if (m !== 1'b0 || d !== 32'hBBBB_BBBB) begin n_fail++; $display("FAIL err_clean_hit: got ar=%b %h want 0 bbbbbbbb", m, d); end
    n_tests++; if (hit_cnt_o !== 32'd4 || miss_cnt_o !== 32'd6) begin n_fail++; $display("FAIL err_cnt: got %0d/%0d want 4/6", hit_cnt_o, miss_cnt_o); end
  endtask

  task automatic test_flush();
    logic [31:0] d, ara; logic [7:0] arl; logic [2:0] ars; bit m, to; int lat, n;
    arvalid_i = 1'b1; araddr_i = 32'h8000_0080;
    tick();
    arvalid_i = 1'b0;
    n = 0;
    while (!io_master_arvalid && n < 10) begin tick(); n++; end
    n_tests++; if (io_master_arvalid !== 1'b1) begin n_fail++; $display("FAIL flush_ar_timeout: got %b want 1", io_master_arvalid); end
    io_master_arready = 1'b1;
    tick();
    io_master_arready = 1'b0;
    io_master_rvalid = 1'b1; io_master_rdata = 64'hD1D1D1D1_D0D0D0D0; io_master_rlast = 1'b0; flush_i = 1'b1;
    #1;
    n_tests++; if (arready_o !== 1'b0) begin n_fail++; $display("FAIL flush_arready_refill: got %b want 0", arready_o); end
    tick();
    flush_i = 1'b0; io_master_rdata = 64'hD3D3D3D3_D2D2D2D2; io_master_rlast = 1'b1;
    tick();
    io_master_rvalid = 1'b0; io_master_rlast = 1'b0;
    n_tests++; if (rvalid_o !== 1'b1 || rdata_o !== 32'hD0D0_D0D0) begin n_fail++; $display("FAIL flush_resp: got %b %h want 1 d0d0d0d0", rvalid_o, rdata_o); end
    tick();
    n_tests++; if (arready_o !== 1'b0) begin n_fail++; $display("FAIL flush_pending_arready: got %b want 0", arready_o); end
    tick();
    n_tests++; if (arready_o !== 1'b1) begin n_fail++; $display("FAIL flush_done_arready: got %b want 1", arready_o); end
    fetch(32'h8000_0080, 64'hE1E1E1E1_E0E0E0E0, 64'hE3E3E3E3_E2E2E2E2, 2'b00, d, m, ara, arl, ars, lat, to);
    n_tests++; if (m !== 1'b1 || d !== 32'hE0E0_E0E0) begin n_fail++; $display("FAIL flush_refetch: got ar=%b %h want 1 e0e0e0e0", m, d); end
    fetch(32'h8000_0100, 64'hF1F1F1F1_F0F0F0F0, 64'hF3F3F3F3_F2F2F2F2, 2'b00, d, m, ara, arl, ars, lat, to);
    n_tests++; if (m !== 1'b1 || d !== 32'hF0F0_F0F0) begin n_fail++; $display("FAIL flush_other_line: got ar=%b %h want 1 f0f0f0f0", m, d); end
    n_tests++; if (hit_cnt_o !== 32'd4 || miss_cnt_o !== 32'd9) begin n_fail++; $display("FAIL flush_cnt_kept: got %0d/%0d want 4/9", hit_cnt_o, miss_cnt_o); end
    flush_i = 1'b1; arvalid_i = 1'b1; araddr_i = 32'h8000_0100;
    #1;
    n_tests++; if (arready_o !== 1'b0) begin n_fail++; $display("FAIL flush_idle_arready: got %b want 0", arready_o); end
    tick();
    flush_i = 1'b0; arvalid_i = 1'b0;
    #1;
    n_tests++; if (arready_o !== 1'b1) begin n_fail++; $display("FAIL flush_idle_no_accept: got %b want 1", arready_o); end
    fetch(32'h8000_0100, 64'h12121212_34343434, 64'h56565656_78787878, 2'b00, d, m, ara, arl, ars, lat, to);
    n_tests++; if (m !== 1'b1 || d !== 32'h3434_3434) begin n_fail++; $display("FAIL flush_idle_miss: got ar=%b %h want 1 34343434", m, d); end
  endtask

  task automatic test_reset_midrefill();
    logic [31:0] d, ara; logic [7:0] arl; logic [2:0] ars; bit m, to; int lat, n;
    arvalid_i = 1'b1; araddr_i = 32'h8000_0300;
    tick();
    arvalid_i = 1'b0;
    n = 0;
    while (!io_master_arvalid && n < 10) begin tick(); n++; end
    io_master_arready = 1'b1;
    tick();
    io_master_arready = 1'b0;
    io_master_rvalid = 1'b1; io_master_rdata = 64'h0BAD0BAD_0BAD0BAD; io_master_rlast = 1'b0;
    tick();
    io_master_rdata = 64'hDEADDEAD_DEADDEAD; io_master_rlast = 1'b1; reset = 1'b0;
    #1;
    n_tests++; if (arready_o !== 1'b0 || rvalid_o !== 1'b0 || rdata_o !== 32'h0) begin n_fail++; $display("FAIL midrst_slave_out: got %b %b %h want 0 0 0", arready_o, rvalid_o, rdata_o); end
    n_tests++; if (io_master_rready !== 1'b0 || io_master_arvalid !== 1'b0 || io_master_araddr !== 32'h0 || io_master_arlen !== 8'h0) begin n_fail++; $display("FAIL midrst_axi_out: got %b %b %h %h want 0 0 0 0", io_master_rready, io_master_arvalid, io_master_araddr, io_master_arlen); end
    n_tests++; if (hit_cnt_o !== 32'd0 || miss_cnt_o !== 32'd0) begin n_fail++; $display("FAIL midrst_cnt: got %0d/%0d want 0/0", hit_cnt_o, miss_cnt_o); end
    tick();
    reset = 1'b1;
    tick();
    n_tests++; if (io_master_rready !== 1'b0 || rvalid_o !== 1'b0 || arready_o !== 1'b1) begin n_fail++; $display("FAIL midrst_stray: got rready=%b rvalid=%b arready=%b want 0 0 1", io_master_rready, rvalid_o, arready_o); end
    io_master_rvalid = 1'b0; io_master_rlast = 1'b0;
    fetch(32'h8000_0300, 64'h13131313_24242424, 64'h35353535_46464646, 2'b00, d, m, ara, arl, ars, lat, to);
    n_tests++; if (m !== 1'b1 || d !== 32'h2424_2424) begin n_fail++; $display("FAIL midrst_refetch: got ar=%b %h want 1 24242424", m, d); end
    n_tests++; if (miss_cnt_o !== 32'd1 || hit_cnt_o !== 32'd0) begin n_fail++; $display("FAIL midrst_cnt_after: got %0d/%0d want 1/0", miss_cnt_o, hit_cnt_o); end
  endtask

  task automatic test_stall();
    int n;
    rready_i = 1'b0;
    arvalid_i = 1'b1; araddr_i = 32'h8000_0308;
    tick();
    arvalid_i = 1'b0;
    n = 0;
    while (!rvalid_o && n < 10) begin tick(); n++; end
    for (int i = 0; i < 5; i++) begin
      n_tests++; if (rvalid_o !== 1'b1 || rdata_o !== 32'h4646_4646) begin n_fail++; $display("FAIL stall_hold_%0d: got %b %h want 1 46464646", i, rvalid_o, rdata_o); end
      tick();
    end
    rready_i = 1'b1;
    tick();
    n_tests++; if (rvalid_o !== 1'b0 || rdata_o !== 32'h0) begin n_fail++; $display("FAIL stall_release: got %b %h want 0 0", rvalid_o, rdata_o); end
    n_tests++; if (hit_cnt_o !== 32'd1) begin n_fail++; $display("FAIL stall_hit_cnt: got %0d want 1", hit_cnt_o); end
  endtask

  initial begin
    test_reset();
    test_miss();
    test_hit();
    test_lru();
    test_err_refill();
    test_flush();
    test_reset_midrefill();
    test_stall();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
